// File: rtl/chanel_scheduler.sv
// Round-robin scheduler that serialises per-channel (ac, ph) samples from
// CHANELS parallel engines into one valid/address/data stream.
module chanel_scheduler #(
  parameter int CHANELS = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [CHANELS-1:0]         i_req_vld,
  input  logic [CHANELS*WIDTH-1:0]   i_req_ac,
  input  logic [CHANELS*WIDTH-1:0]   i_req_ph,
  input  logic                       i_rdy,
  input  logic                       i_clr_ovf,
  output logic                       o_vld,
  output logic [$clog2(CHANELS)-1:0] o_addres,
  output logic [WIDTH-1:0]           o_ac,
  output logic [WIDTH-1:0]           o_ph,
  output logic [CHANELS-1:0]         o_pending,
  output logic [CHANELS-1:0]         o_ovf
);

  localparam int AW = $clog2(CHANELS);

  logic [CHANELS-1:0] pend;
  logic [WIDTH-1:0]   ac_buf [CHANELS];
  logic [WIDTH-1:0]   ph_buf [CHANELS];
  logic [AW-1:0]      ptr;

  logic               grant_any;
  logic [AW-1:0]      grant_idx;
  logic [CHANELS-1:0] grant_mask;

  assign o_pending = pend;

  // Two passes give the circular search from ptr without modulo arithmetic:
  // first the channels at or above ptr, then the ones below it.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred on any path.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_mask = '0;
    if (i_rdy) begin
      for (int k = 0; k < CHANELS; k++) begin
        if (!grant_any && pend[k] && (AW'(k) >= ptr)) begin
          grant_any = 1'b1;
          grant_idx = AW'(k);
        end
      end
      for (int k = 0; k < CHANELS; k++) begin
        if (!grant_any && pend[k]) begin
          grant_any = 1'b1;
          grant_idx = AW'(k);
        end
      end
      if (grant_any) grant_mask[grant_idx] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' only; the buffer memories
  // are reset too, so a reset leaves no stale sample visible anywhere.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_vld    <= 1'b0;
      o_addres <= '0;
      o_ac     <= '0;
      o_ph     <= '0;
      pend     <= '0;
      o_ovf    <= '0;
      ptr      <= '0;
      for (int k = 0; k < CHANELS; k++) begin
        ac_buf[k] <= '0;
        ph_buf[k] <= '0;
      end
    end else begin
      if (grant_any) begin
        o_vld    <= 1'b1;
        o_addres <= grant_idx;
        o_ac     <= ac_buf[grant_idx];
        o_ph     <= ph_buf[grant_idx];
        ptr      <= (grant_idx == AW'(CHANELS - 1)) ? '0 : grant_idx + AW'(1);
      end else begin
        o_vld <= 1'b0;
      end

      if (i_clr_ovf) o_ovf <= '0;

      // A granted slot is free this cycle, so a same-cycle strobe refills it
      // losslessly; per-bit overflow sets come after the clear and win.
      for (int k = 0; k < CHANELS; k++) begin
        if (i_req_vld[k]) begin
          if (!pend[k] || grant_mask[k]) begin
            ac_buf[k] <= i_req_ac[k*WIDTH +: WIDTH];
            ph_buf[k] <= i_req_ph[k*WIDTH +: WIDTH];
            pend[k]   <= 1'b1;
          end else begin
            o_ovf[k] <= 1'b1;
          end
        end else if (grant_mask[k]) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chanel_scheduler.sv
// Directed testbench for chanel_scheduler: hand-computed vectors covering
// reset, latency, round-robin order, overflow, drain/refill and mid-run reset.
module tb_chanel_scheduler;

  localparam int CHANELS = 4;
  localparam int WIDTH   = 32;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic [CHANELS-1:0]       i_req_vld;
  logic [CHANELS*WIDTH-1:0] i_req_ac;
  logic [CHANELS*WIDTH-1:0] i_req_ph;
  logic                     i_rdy;
  logic                     i_clr_ovf;
  logic                     o_vld;
  logic [1:0]               o_addres;
  logic [WIDTH-1:0]         o_ac;
  logic [WIDTH-1:0]         o_ph;
  logic [CHANELS-1:0]       o_pending;
  logic [CHANELS-1:0]       o_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  chanel_scheduler #(.CHANELS(CHANELS), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_req_vld (i_req_vld),
    .i_req_ac  (i_req_ac),
    .i_req_ph  (i_req_ph),
    .i_rdy     (i_rdy),
    .i_clr_ovf (i_clr_ovf),
    .o_vld     (o_vld),
    .o_addres  (o_addres),
    .o_ac      (o_ac),
    .o_ph      (o_ph),
    .o_pending (o_pending),
    .o_ovf     (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] ac, input logic [WIDTH-1:0] ph);
    i_req_vld[k]             = 1'b1;
    i_req_ac[k*WIDTH +: WIDTH] = ac;
    i_req_ph[k*WIDTH +: WIDTH] = ph;
  endtask

  task automatic check_pulse(input string tag, input logic [1:0] addr,
                             input logic [WIDTH-1:0] ac, input logic [WIDTH-1:0] ph);
    check({tag, "_vld"},  64'(o_vld),    64'd1);
    check({tag, "_addr"}, 64'(o_addres), 64'(addr));
    check({tag, "_ac"},   64'(o_ac),     64'(ac));
    check({tag, "_ph"},   64'(o_ph),     64'(ph));
  endtask

  initial begin
    rstn      = 1'b0;
    i_req_vld = '0;
    i_req_ac  = '0;
    i_req_ph  = '0;
    i_rdy     = 1'b1;
    i_clr_ovf = 1'b0;
    tick();
    tick();
    rstn = 1'b1;

    // Idle after reset: everything stays zero.
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_vld",  64'(o_vld),     64'd0);
      check("idle_pend", 64'(o_pending), 64'd0);
      check("idle_ovf",  64'(o_ovf),     64'd0);
      check("idle_data", {o_addres, o_ac, o_ph}, 64'd0);
    end

    // All four channels strobe together with ptr=0: issued 0,1,2,3.
    for (int k = 0; k < CHANELS; k++) set_ch(k, WIDTH'(k + 1), WIDTH'(32'h100 + k));
    tick();
    i_req_vld = '0;
    check("all_e0_vld",  64'(o_vld),     64'd0);
    check("all_e0_pend", 64'(o_pending), 64'hF);
    tick();
    check_pulse("all_g0", 2'd0, 32'd1, 32'h100);
    check("all_g0_pend", 64'(o_pending), 64'hE);
    tick();
    check_pulse("all_g1", 2'd1, 32'd2, 32'h101);
    check("all_g1_pend", 64'(o_pending), 64'hC);
    tick();
    check_pulse("all_g2", 2'd2, 32'd3, 32'h102);
    check("all_g2_pend", 64'(o_pending), 64'h8);
    tick();
    check_pulse("all_g3", 2'd3, 32'd4, 32'h103);
    check("all_g3_pend", 64'(o_pending), 64'h0);
    tick();
    check("all_end_vld", 64'(o_vld), 64'd0);

    // Single strobe on channel 2: pulse exactly two edges after the strobe.
    set_ch(2, 32'h0000_1234, 32'hFFFF_FF00);
    tick();
    i_req_vld = '0;
    check("one_e0_vld",  64'(o_vld),     64'd0);
    check("one_e0_pend", 64'(o_pending), 64'h4);
    tick();
    check_pulse("one_g", 2'd2, 32'h0000_1234, 32'hFFFF_FF00);
    tick();
    check("one_end_vld", 64'(o_vld), 64'd0);
    check("one_hold_ac", 64'(o_ac),  64'h1234);

    // Fairness: ptr=3, channels 0 and 3 strobe together -> 3 first, then 0.
    set_ch(0, 32'hA0, 32'hB0);
    set_ch(3, 32'hA3, 32'hB3);
    tick();
    i_req_vld = '0;
    check("fair_pend", 64'(o_pending), 64'h9);
    tick();
    check_pulse("fair_first", 2'd3, 32'hA3, 32'hB3);
    tick();
    check_pulse("fair_second", 2'd0, 32'hA0, 32'hB0);
    tick();
    check("fair_end_vld", 64'(o_vld), 64'd0);

    // Overflow with i_rdy=0: second strobe on channel 1 is dropped.
    i_rdy = 1'b0;
    set_ch(1, 32'h11, 32'h21);
    tick();
    check("ovf_pend", 64'(o_pending), 64'h2);
    set_ch(1, 32'hAA, 32'hBB);
    tick();
    i_req_vld = '0;
    check("ovf_vld",  64'(o_vld), 64'd0);
    check("ovf_flag", 64'(o_ovf), 64'h2);
    tick();
    check("ovf_stall_vld", 64'(o_vld), 64'd0);
    i_rdy = 1'b1;
    tick();
    check_pulse("ovf_old", 2'd1, 32'h11, 32'h21);
    check("ovf_sticky", 64'(o_ovf), 64'h2);
    tick();
    check("ovf_end_vld", 64'(o_vld), 64'd0);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    check("ovf_clr", 64'(o_ovf), 64'h0);

    // Drain and refill of channel 0 in the same cycle is lossless.
    set_ch(0, 32'h33, 32'h43);
    tick();
    set_ch(0, 32'h55, 32'h65);
    tick();
    i_req_vld = '0;
    check_pulse("refill_old", 2'd0, 32'h33, 32'h43);
    check("refill_pend", 64'(o_pending), 64'h1);
    check("refill_ovf",  64'(o_ovf),     64'h0);
    tick();
    check_pulse("refill_new", 2'd0, 32'h55, 32'h65);
    check("refill_end_pend", 64'(o_pending), 64'h0);

    // Mid-run reset discards pending samples and produces no pulse.
    i_rdy = 1'b0;
    set_ch(1, 32'h77, 32'h87);
    set_ch(3, 32'h79, 32'h89);
    tick();
    i_req_vld = '0;
    check("rst_pre_pend", 64'(o_pending), 64'hA);
    i_rdy = 1'b1;
    rstn  = 1'b0;
    tick();
    check("rst_pend", 64'(o_pending), 64'h0);
    check("rst_vld",  64'(o_vld),     64'd0);
    check("rst_data", {o_addres, o_ac, o_ph}, 64'd0);
    rstn = 1'b1;
    tick();
    check("rst_after_vld", 64'(o_vld), 64'd0);
    tick();
    check("rst_after2_vld",  64'(o_vld),     64'd0);
    check("rst_after2_pend", 64'(o_pending), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
